// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Fixed 32-iteration shift-add multiply and restoring divide on operand magnitudes.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        start_mul,
    input  logic        start_div,
    input  logic        Unsigned,
    input  logic        WriteHi,
    input  logic        WriteLo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      r_state;
    logic [4:0]  r_count;
    logic [63:0] r_acc;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_op1;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div0;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;

    logic        w_op1_neg;
    logic        w_op2_neg;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic [32:0] w_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic [63:0] w_div_next;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_remd;

    assign w_op1_neg = !Unsigned && op1[31];
    assign w_op2_neg = !Unsigned && op2[31];
    assign w_mag1    = w_op1_neg ? -op1 : op1;
    assign w_mag2    = w_op2_neg ? -op2 : op2;

    // Multiply step: {partial product, remaining multiplier bits} shifted right once.
    assign w_sum      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a} : 33'd0);
    assign w_mul_next = {w_sum, r_acc[31:1]};

    // Divide step: {remainder, dividend/quotient} shifted left, trial subtract.
    assign w_rem_sh   = {r_acc[63:32], r_acc[31]};
    assign w_diff     = w_rem_sh - {1'b0, r_b};
    assign w_div_next = w_diff[32] ? {w_rem_sh[31:0], r_acc[30:0], 1'b0}
                                   : {w_diff[31:0],   r_acc[30:0], 1'b1};

    assign w_prod = r_neg_q ? -w_mul_next : w_mul_next;
    assign w_quot = r_neg_q ? -w_div_next[31:0] : w_div_next[31:0];
    assign w_remd = r_neg_r ? -w_div_next[63:32] : w_div_next[63:32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= 5'd0;
            r_acc    <= 64'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_op1    <= 32'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (WriteHi) r_hi <= op1;
                    if (WriteLo) r_lo <= op1;
                    if (start_mul || start_div) begin
                        r_state  <= CALC;
                        r_count  <= 5'd0;
                        r_busy   <= 1'b1;
                        r_is_div <= !start_mul;
                        r_a      <= w_mag1;
                        r_b      <= w_mag2;
                        r_op1    <= op1;
                        r_neg_q  <= w_op1_neg ^ w_op2_neg;
                        r_neg_r  <= w_op1_neg;
                        r_div0   <= (op2 == 32'd0);
                        // Multiplier starts in the low half; dividend likewise.
                        r_acc    <= start_mul ? {32'd0, w_mag2} : {32'd0, w_mag1};
                    end
                end
                CALC: begin
                    r_acc   <= r_is_div ? w_div_next : w_mul_next;
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        if (!r_is_div) begin
                            r_hi <= w_prod[63:32];
                            r_lo <= w_prod[31:0];
                        end else if (r_div0) begin
                            r_hi <= r_op1;
                            r_lo <= 32'hFFFF_FFFF;
                        end else begin
                            r_hi <= w_remd;
                            r_lo <= w_quot;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = r_busy;
    assign done = r_done;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, fixed latency, busy/done timing,
// ignored requests while busy, IDLE writes to HI/LO and reset abort.
module tb_muldiv_unit;
    logic        clk;
    logic        reset;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start_mul;
    logic        start_div;
    logic        Unsigned;
    logic        WriteHi;
    logic        WriteLo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    muldiv_unit dut (
        .clk       (clk),
        .reset     (reset),
        .op1       (op1),
        .op2       (op2),
        .start_mul (start_mul),
        .start_div (start_div),
        .Unsigned  (Unsigned),
        .WriteHi   (WriteHi),
        .WriteLo   (WriteLo),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One operation: start sampled at edge E, result checked at E+32, idle at E+33.
    // inj drives start/write requests into the CALC phase; wr asserts WriteHi/WriteLo with the start.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic uns, input logic mul, input logic div,
                          input logic inj, input logic wr,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        int busy_cnt;
        int done_cnt;
        @(negedge clk);
        op1 = a; op2 = b; Unsigned = uns;
        start_mul = mul; start_div = div;
        WriteHi = wr; WriteLo = wr;
        @(posedge clk);
        #1;
        start_mul = 1'b0; start_div = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
        op1 = ~a; op2 = ~b; Unsigned = ~uns;
        busy_cnt = 0;
        done_cnt = 0;
        if (busy) busy_cnt++;
        if (wr) begin
            chk({tag, " wr_hi"}, hi, a);
            chk({tag, " wr_lo"}, lo, a);
        end
        prev_hi = hi;
        prev_lo = lo;
        for (int k = 1; k <= 33; k++) begin
            if (inj && k == 5) begin
                start_div = 1'b1; start_mul = 1'b1; WriteHi = 1'b1; WriteLo = 1'b1;
            end
            if (inj && k == 6) begin
                start_div = 1'b0; start_mul = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
            end
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (k == 31) begin
                chk({tag, " hi_hold"}, hi, prev_hi);
                chk({tag, " lo_hold"}, lo, prev_lo);
            end
            if (k == 32) begin
                chk({tag, " hi"}, hi, exp_hi);
                chk({tag, " lo"}, lo, exp_lo);
                chk({tag, " done_at_E32"}, {31'd0, done}, 32'd1);
            end
            if (k == 33) begin
                chk({tag, " busy_after"}, {31'd0, busy}, 32'd0);
                chk({tag, " hi_kept"}, hi, exp_hi);
            end
        end
        chk({tag, " busy_cycles"}, busy_cnt, 33);
        chk({tag, " done_cycles"}, done_cnt, 1);
        $display("op %s a=%h b=%h uns=%0d -> hi=%h lo=%h", tag, a, b, uns, hi, lo);
    endtask

    initial begin
        reset = 1'b1;
        op1 = 32'd0; op2 = 32'd0; Unsigned = 1'b0;
        start_mul = 1'b0; start_div = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("smul_m2x3", 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
               32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("umul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
               32'hFFFF_FFFE, 32'h0000_0001);
        run_op("udiv_100_7", 32'd100, 32'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
               32'd2, 32'd14);
        run_op("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("sdiv_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
               32'h0000_0000, 32'h8000_0000);
        run_op("sdiv_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
               32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("udiv_5_0", 32'd5, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
               32'd5, 32'hFFFF_FFFF);

        // MTHI in IDLE leaves LO alone.
        @(negedge clk);
        op1 = 32'h0000_1234; WriteHi = 1'b1;
        @(posedge clk);
        #1;
        WriteHi = 1'b0;
        chk("mthi hi", hi, 32'h0000_1234);
        chk("mthi lo", lo, 32'hFFFF_FFFF);
        chk("mthi busy", {31'd0, busy}, 32'd0);
        $display("op mthi op1=00001234 -> hi=%h lo=%h", hi, lo);

        // Both starts together select multiply; same-cycle writes land first.
        run_op("both_6x7", 32'd6, 32'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
               32'd0, 32'd42);

        // Reset in the middle of a divide aborts it immediately.
        @(negedge clk);
        op1 = 32'd100; op2 = 32'd7; Unsigned = 1'b1; start_div = 1'b1;
        @(posedge clk);
        #1;
        start_div = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        $display("op reset_abort -> hi=%h lo=%h busy=%0d", hi, lo, busy);
        @(negedge clk);
        reset = 1'b0;

        run_op("after_rst_div", 32'd100, 32'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
               32'd2, 32'd14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
